nco_freq_meter: RTL

Gated frequency counter on the receiving end of the NCO output: measures the square wave produced by tt_um_nco, e.g. the NCO output MSB looped back through a pin.
Counts rising edges of an asynchronous input over a programmable gate window of clock cycles and reports the count with a one-cycle valid strobe.
Software or the bench recovers the tuning word from it: FTW ≈ count·2^ACC_W / gate_len.
Sits beside the NCO in the same tile; it is the measurement/readback path for the generator.

---
 rtl/nco_meas_pkg.sv | 20 ++
 rtl/nco_sync_edge.sv | 31 +++
 rtl/nco_freq_meter.sv | 124 ++++++++++++
 3 files changed

// File: rtl/nco_meas_pkg.sv
// Shared types and defaults for the NCO frequency meter: FSM state encoding,
// default widths and the counter saturation helper.
package nco_meas_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_GATE = 2'd1,
    S_DONE = 2'd2
  } meas_state_t;

  localparam int DEF_GATE_W      = 16;
  localparam int DEF_CNT_W       = 12;
  localparam int DEF_SYNC_STAGES = 2;

  // All-ones value of a w-bit counter (valid for w < 32).
  function automatic int cnt_max(input int w);
    return (1 << w) - 1;
  endfunction

endpackage

// File: rtl/nco_sync_edge.sv
// Multi-flop synchroniser for an asynchronous input followed by a history flop;
// rise is high for one cycle per synchronised 0->1 transition.
module nco_sync_edge
  import nco_meas_pkg::*;
#(
  parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic clk,
  input  logic rst,
  input  logic d_async,
  output logic rise
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_hist;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its neighbour; blocking here would collapse the chain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync <= '0;
      r_hist <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], d_async};
      r_hist <= r_sync[SYNC_STAGES-1];
    end
  end

  assign rise = r_sync[SYNC_STAGES-1] & ~r_hist;

endmodule

// File: rtl/nco_freq_meter.sv
// Gated frequency counter: counts synchronised rising edges of sig_in over a
// gate_len-cycle window. Define NCO_MEAS_CONTINUOUS_EN for back-to-back windows.
module nco_freq_meter
  import nco_meas_pkg::*;
#(
  parameter int GATE_W      = DEF_GATE_W,
  parameter int CNT_W       = DEF_CNT_W,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sig_in,
  input  logic              start,
  input  logic [GATE_W-1:0] gate_len,
  output logic [CNT_W-1:0]  meas_count,
  output logic              meas_valid,
  output logic              busy,
  output logic              overflow
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(cnt_max(CNT_W));

  meas_state_t       r_state;
  meas_state_t       w_state_nxt;
  logic              w_rise;
  logic              w_load;
  logic [GATE_W-1:0] w_load_len;
  logic [GATE_W-1:0] r_gate_rem;
  logic [CNT_W-1:0]  r_edge_cnt;
  logic              r_sat;
  logic [CNT_W-1:0]  r_meas_count;
  logic              r_meas_valid;
  logic              r_overflow;
`ifdef NCO_MEAS_CONTINUOUS_EN
  logic [GATE_W-1:0] r_gate_len;
`endif

  nco_sync_edge #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync_edge (
    .clk    (clk),
    .rst    (rst),
    .d_async(sig_in),
    .rise   (w_rise)
  );

  // NOTE: every signal written here gets a default first, so no path through
  // the case can leave one unassigned and infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_load_len  = gate_len;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_load      = 1'b1;
          w_state_nxt = (gate_len == '0) ? S_DONE : S_GATE;
        end
      end
      S_GATE: begin
        if (r_gate_rem == GATE_W'(1)) w_state_nxt = S_DONE;
      end
      S_DONE: begin
`ifdef NCO_MEAS_CONTINUOUS_EN
        w_load      = 1'b1;
        w_load_len  = r_gate_len;
        w_state_nxt = (r_gate_len == '0) ? S_DONE : S_GATE;
`else
        w_state_nxt = S_IDLE;
`endif
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // NOTE: nothing here is a memory array, so every flop is in the reset list
  // and an aborted window leaves no stale count behind.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_gate_rem   <= '0;
      r_edge_cnt   <= '0;
      r_sat        <= 1'b0;
      r_meas_count <= '0;
      r_meas_valid <= 1'b0;
      r_overflow   <= 1'b0;
    end else begin
      if (w_load) begin
        r_gate_rem <= w_load_len;
        r_edge_cnt <= '0;
        r_sat      <= 1'b0;
      end else if (r_state == S_GATE) begin
        r_gate_rem <= r_gate_rem - GATE_W'(1);
        if (w_rise) begin
          if (r_edge_cnt == CNT_MAX) r_sat <= 1'b1;
          else                       r_edge_cnt <= r_edge_cnt + CNT_W'(1);
        end
      end
      // Result registers read the pre-load counter even when DONE reloads it.
      r_meas_valid <= (r_state == S_DONE);
      if (r_state == S_DONE) begin
        r_meas_count <= r_edge_cnt;
        r_overflow   <= r_sat;
      end
    end
  end

`ifdef NCO_MEAS_CONTINUOUS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                            r_gate_len <= '0;
    else if (r_state == S_IDLE && start) r_gate_len <= gate_len;
  end
`endif

  assign meas_count = r_meas_count;
  assign meas_valid = r_meas_valid;
  assign overflow   = r_overflow;
  assign busy       = (r_state != S_IDLE);

endmodule
